// File: rtl/cpu_pc_stack_if.sv
// Control and bus bundle between the SAP sequencer and the program counter.
// The sequencer drives the master side; the PC block is the slave.
interface cpu_pc_stack_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] bus_in;
  logic [ADDR_W-1:0] bus_out;
  logic              lp;
  logic              c;
  logic              call;
  logic              ret;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output bus_in, lp, c, call, ret,
    input  bus_out, sp, stack_full, stack_empty, ovf_err, unf_err
  );

  modport slave (
    input  bus_in, lp, c, call, ret,
    output bus_out, sp, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/cpu_pc_stack.sv
// Program counter with hardware return-address stack for the SAP CPU.
// One action per cycle, priority ret > call > lp > c; error flags are sticky.
module cpu_pc_stack #(
  parameter int                 ADDR_W      = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic          clk,
  input  logic          rst,
  cpu_pc_stack_if.slave pc_if
);
  localparam int              SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]                   r_pc;
  logic [SP_W-1:0]                     r_sp;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0]  r_stack;
  logic                                r_ovf;
  logic                                r_unf;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_full   = (r_sp == FULL);
  assign w_empty  = (r_sp == '0);
  assign w_pop    = pc_if.ret && !w_empty;
  // ret wins over call, so push and pop never coincide on the array
  assign w_push   = !pc_if.ret && pc_if.call && !w_full;

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (r_sp == SP_W'(i + 1)) w_top = r_stack[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc  <= RESET_ADDR;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (pc_if.ret) begin
      if (w_pop) begin
        r_pc <= w_top;
        r_sp <= r_sp - SP_W'(1);
      end else begin
        r_unf <= 1'b1;
      end
    end else if (pc_if.call) begin
      if (w_push) begin
        r_pc <= pc_if.bus_in;
        r_sp <= r_sp + SP_W'(1);
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (pc_if.lp) begin
      r_pc <= pc_if.bus_in;
    end else if (pc_if.c) begin
      r_pc <= w_pc_inc;
    end
  end

  // Stack contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (rst && w_push && r_sp == SP_W'(i)) r_stack[i] <= w_pc_inc;
  end

  assign pc_if.bus_out     = r_pc;
  assign pc_if.sp          = r_sp;
  assign pc_if.stack_full  = w_full;
  assign pc_if.stack_empty = w_empty;
  assign pc_if.ovf_err     = r_ovf;
  assign pc_if.unf_err     = r_unf;
endmodule

// File: doc/cpu_pc_stack.md
Name: cpu_pc_stack

Overview:
- Parametrised program counter for the SAP CPU family, generalised from the fixed 4-bit PC.
- Adds configurable address width and a hardware return-address stack, so the control sequencer can issue subroutine CALL/RET alongside jump (load) and increment.
- Sits between the bus and the memory address register; the PC value is always driven on bus_out.

Parameters:
- ADDR_W, 8, PC/address width in bits (≥2).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_ADDR, 0, PC value loaded on reset (ADDR_W bits).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-low reset, sampled on rising clk.
- bus_in  input  ADDR_W  jump/call target address.
- bus_out  output  ADDR_W  current PC value (continuously driven, not tri-stated).
- lp  input  1  load PC from bus_in (jump).
- c  input  1  count enable (PC+1).
- call  input  1  push PC+1, then load bus_in.
- ret  input  1  pop top of stack into PC.
- sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- ovf_err  output  1  sticky: a call was attempted while full.
- unf_err  output  1  sticky: a ret was attempted while empty.

Behaviour:
- Reset (rst==0 at rising clk): PC=RESET_ADDR, sp=0, ovf_err=0, unf_err=0. Stack contents are don't-care. Reset overrides all controls, including mid-call/ret.
- Priority per cycle: ret > call > lp > c > hold. Exactly one action per cycle; lower-priority requests are discarded, not queued.
- ret, stack non-empty: PC <= stack[sp-1]; sp <= sp-1. Takes effect in 1 cycle.
- ret, stack empty: PC holds; sp holds; unf_err <= 1.
- call, stack not full: stack[sp] <= PC+1 (mod 2^ADDR_W); PC <= bus_in; sp <= sp+1.
- call, stack full: PC holds; stack unchanged; ovf_err <= 1. The call is not partially executed.
- lp: PC <= bus_in.
- c: PC <= PC+1, truncated to ADDR_W. Max value wraps to 0.
- No control asserted: all state holds.
- Return address wrap: a call at PC=2^ADDR_W−1 pushes 0.
- Outputs: bus_out=PC, and stack_full/stack_empty decode from sp; all are combinational from registers, no added latency. A new value is visible the cycle after the edge that produced it.
- ovf_err and unf_err clear only on reset.
- Stack storage: register array indexed by sp. No read-during-write hazard exists because ret and call are mutually exclusive by priority.

Test Plan:
- Reset/count (ADDR_W=8): rst low for 1 edge, then c=1 for 3 cycles → bus_out 0,1,2,3; sp=0; stack_empty=1.
- Wrap: lp with bus_in=0xFF, then c=1 → bus_out 0xFF, then 0x00; no flags set.
- Call/return nesting: PC=0x10, call bus_in=0x40 → PC=0x40, sp=1. Next, call bus_in=0x80 → PC=0x80, sp=2. Then ret → 0x41, sp=1; ret → 0x11, sp=0, stack_empty=1.
- Overflow (STACK_DEPTH=4): perform 4 calls → stack_full=1. 5th call with bus_in=0x22 → PC unchanged, sp=4, ovf_err=1. Then 4 rets return the correct addresses in LIFO order; ovf_err stays 1.
- Underflow and priority: at sp=0 assert ret+lp with bus_in=0x55 → PC unchanged, unf_err=1 (lp discarded). Then call+lp+c with bus_in=0x30 at PC=0x05 → PC=0x30, top of stack=0x06.
- Sync reset mid-operation: with sp=2 and errors set, assert rst=0 together with call → next cycle PC=RESET_ADDR, sp=0, both errors 0. rst going low between clock edges causes no change until the next rising clk.
